pc_fetch_sequencer: RTL and testbench

//   Owns the CPU program counter and sequences each instruction: fetch from

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/pc_next_calc.sv | 22 ++
 rtl/pc_fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU front end: sequencer states, default
// PC parameters and the instruction word field layout.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_PC_STEP     = 4;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  // Instruction word layout: OPCODE | DEST | SRC1 | IMM
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned DEST_MSB   = 23;
  localparam int unsigned DEST_LSB   = 16;
  localparam int unsigned SRC1_MSB   = 15;
  localparam int unsigned SRC1_LSB   = 8;
  localparam int unsigned IMM_MSB    = 7;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential step plus an optional signed word offset,
// all arithmetic modulo 2^ADDR_W.
module pc_next_calc #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [7:0]        offset_i,
  input  logic              taken_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] off_ext_s;
  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] branch_s;

  assign off_ext_s = {{(ADDR_W-8){offset_i[7]}}, offset_i};
  assign step_s    = ADDR_W'(PC_STEP);
  assign branch_s  = taken_i ? (off_ext_s * step_s) : {ADDR_W{1'b0}};
  assign next_pc_o = pc_i + step_s + branch_s;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch/issue sequencer for the CPU front end.
// Optional fetch timeout with sticky FETCH_ERR and HALT: define FETCH_TIMEOUT_EN.
module pc_fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       PC_STEP     = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] PC,
  output logic              IMEM_READ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_BUSYWAIT,
  input  logic [31:0]       IMEM_RDATA,
  output logic [31:0]       INSTRUCTION,
  output logic              INSTR_VALID,
  input  logic              STALL_IN,
  input  logic              JUMP,
  input  logic              BRANCH,
  input  logic              ZERO,
  input  logic [7:0]        OFFSET,
  output logic              FETCH_ERR
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              read_q, read_d;
  logic              valid_q, valid_d;
  logic              taken_s;
  logic [ADDR_W-1:0] next_pc_s;

  assign taken_s = JUMP | (BRANCH & ZERO);

  pc_next_calc #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next_calc (
    .pc_i      (pc_q),
    .offset_i  (OFFSET),
    .taken_i   (taken_s),
    .next_pc_o (next_pc_s)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = {CNT_W{1'b0}};
    err_d   = err_q;
`endif
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_RDATA;
          state_d = ST_ISSUE;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          // counter holds the number of busywait cycles already seen
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_ISSUE: begin
        if (!STALL_IN) begin
          pc_d    = next_pc_s;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    read_d  = (state_d == ST_FETCH);
    valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      read_q  <= read_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign FETCH_ERR = err_q;
`else
  assign FETCH_ERR = 1'b0;
`endif

  assign PC          = pc_q;
  assign IMEM_ADDR   = pc_q;
  assign IMEM_READ   = read_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; inputs change and outputs are checked
// on the falling clock edge. Timeout checks follow FETCH_TIMEOUT_EN.
module tb_pc_fetch_sequencer;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        STALL_IN;
  logic        JUMP;
  logic        BRANCH;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic        FETCH_ERR;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer #(
    .ADDR_W      (32),
    .PC_STEP     (4),
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC            (PC),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_RDATA    (IMEM_RDATA),
    .INSTRUCTION   (INSTRUCTION),
    .INSTR_VALID   (INSTR_VALID),
    .STALL_IN      (STALL_IN),
    .JUMP          (JUMP),
    .BRANCH        (BRANCH),
    .ZERO          (ZERO),
    .OFFSET        (OFFSET),
    .FETCH_ERR     (FETCH_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; IMEM_BUSYWAIT = 1'b0; IMEM_RDATA = 32'h0;
    STALL_IN = 1'b0; JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0; OFFSET = 8'h00;

    // reset held for two cycles
    nxt(); nxt();
    chk("rst_pc", PC, 32'h0);
    chk("rst_read", {31'b0, IMEM_READ}, 32'h0);
    chk("rst_valid", {31'b0, INSTR_VALID}, 32'h0);
    chk("rst_instr", INSTRUCTION, 32'h0);
    chk("rst_err", {31'b0, FETCH_ERR}, 32'h0);
    RESET = 1'b0;
    chk("boot_read", {31'b0, IMEM_READ}, 32'h0);

    nxt();
    chk("f0_read", {31'b0, IMEM_READ}, 32'h1);
    chk("f0_addr", IMEM_ADDR, 32'h0);
    chk("f0_valid", {31'b0, INSTR_VALID}, 32'h0);
    IMEM_RDATA = 32'h0B0100AA;
    nxt();
    chk("i0_instr", INSTRUCTION, 32'h0B0100AA);
    chk("i0_valid", {31'b0, INSTR_VALID}, 32'h1);
    chk("i0_read", {31'b0, IMEM_READ}, 32'h0);
    chk("i0_pc", PC, 32'h0);
    nxt();
    chk("f1_pc", PC, 32'h4);
    chk("f1_addr", IMEM_ADDR, 32'h4);
    chk("f1_valid", {31'b0, INSTR_VALID}, 32'h0);
    IMEM_RDATA = 32'h0B020055;
    nxt();
    chk("i1_instr", INSTRUCTION, 32'h0B020055);
    chk("i1_valid", {31'b0, INSTR_VALID}, 32'h1);
    nxt();
    chk("f2_pc", PC, 32'h8);
    chk("f2_read", {31'b0, IMEM_READ}, 32'h1);

    // busywait for three cycles at PC=8
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("bw_pc", PC, 32'h8);
      chk("bw_valid", {31'b0, INSTR_VALID}, 32'h0);
      chk("bw_read", {31'b0, IMEM_READ}, 32'h1);
    end
    IMEM_BUSYWAIT = 1'b0; IMEM_RDATA = 32'h0C030011;
    nxt();
    chk("bw_issue_valid", {31'b0, INSTR_VALID}, 32'h1);
    chk("bw_issue_instr", INSTRUCTION, 32'h0C030011);

    // taken branch backwards: 8 + 4 - 8 = 4
    BRANCH = 1'b1; ZERO = 1'b1; OFFSET = 8'hFE;
    nxt();
    chk("beq_taken_pc", PC, 32'h4);
    BRANCH = 1'b0; ZERO = 1'b0; OFFSET = 8'h00; IMEM_RDATA = 32'h01020304;
    nxt();
    // jump forward: 4 + 4 + 8 = 16
    JUMP = 1'b1; OFFSET = 8'h02;
    nxt();
    chk("jump_pc", PC, 32'h10);
    JUMP = 1'b0;
    nxt();
    // branch with ZERO=0 is not taken: 16 + 4
    BRANCH = 1'b1; ZERO = 1'b0; OFFSET = 8'h7F;
    nxt();
    chk("beq_not_taken_pc", PC, 32'h14);
    BRANCH = 1'b0;
    nxt();
    // JUMP and BRANCH together, ZERO=0 still taken: 20 + 4 - 12 = 12
    JUMP = 1'b1; BRANCH = 1'b1; ZERO = 1'b0; OFFSET = 8'hFD;
    nxt();
    chk("jump_branch_pc", PC, 32'hC);
    JUMP = 1'b0; BRANCH = 1'b0; OFFSET = 8'h00; IMEM_RDATA = 32'hDEADBEEF;
    nxt();

    // stall four cycles in ISSUE; busywait must be ignored there
    STALL_IN = 1'b1; IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("stall_valid", {31'b0, INSTR_VALID}, 32'h1);
      chk("stall_pc", PC, 32'hC);
      chk("stall_instr", INSTRUCTION, 32'hDEADBEEF);
      chk("stall_read", {31'b0, IMEM_READ}, 32'h0);
    end
    STALL_IN = 1'b0; IMEM_BUSYWAIT = 1'b0;
    nxt();
    chk("stall_release_pc", PC, 32'h10);
    chk("stall_release_valid", {31'b0, INSTR_VALID}, 32'h0);
    nxt();
    // 16 + 4 - 24 = 0xFFFFFFFC, then sequential step wraps to 0
    JUMP = 1'b1; OFFSET = 8'hFA;
    nxt();
    chk("neg_pc", PC, 32'hFFFFFFFC);
    JUMP = 1'b0; OFFSET = 8'h00;
    nxt();
    nxt();
    chk("wrap_pc", PC, 32'h0);
    nxt();
    nxt();
    chk("pre_rst_pc", PC, 32'h4);
    IMEM_BUSYWAIT = 1'b1;
    nxt();
    chk("pre_rst_read", {31'b0, IMEM_READ}, 32'h1);

    // asynchronous reset mid-busywait, checked before any clock edge
    #1 RESET = 1'b1;
    #1;
    chk("async_rst_read", {31'b0, IMEM_READ}, 32'h0);
    chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_valid", {31'b0, INSTR_VALID}, 32'h0);
    nxt();
    RESET = 1'b0;
    nxt();
    chk("to_fetch_read", {31'b0, IMEM_READ}, 32'h1);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("to_wait_err", {31'b0, FETCH_ERR}, 32'h0);
      chk("to_wait_read", {31'b0, IMEM_READ}, 32'h1);
    end
    nxt();
    chk("to_err", {31'b0, FETCH_ERR}, 32'h1);
    chk("to_read", {31'b0, IMEM_READ}, 32'h0);
    chk("to_valid", {31'b0, INSTR_VALID}, 32'h0);
    chk("to_pc", PC, 32'h0);
    IMEM_BUSYWAIT = 1'b0;
    repeat (3) nxt();
    chk("to_err_sticky", {31'b0, FETCH_ERR}, 32'h1);
    chk("to_read_halted", {31'b0, IMEM_READ}, 32'h0);
`else
    repeat (300) nxt();
    chk("no_to_err", {31'b0, FETCH_ERR}, 32'h0);
    chk("no_to_read", {31'b0, IMEM_READ}, 32'h1);
    chk("no_to_pc", PC, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
